adc1410_capture: RTL and testbench
==================================

// Module: adc1410_capture
// PURPOSE
//   Receive-side counterpart of the Zmod DAC path: takes ch1/ch2 14-bit two's-complement samples from the
//   Zmod ADC1410 controller, waits for an armed trigger (immediate / rising / falling level crossing on a
//   selected channel), captures CAPTURE_LEN sample pairs into an internal FIFO and streams them out over a
//   valid/ready interface to the PS/DMA side. Sits between the ADC controller and the AXI-stream bridge.
// PARAMETERS
//   ZMOD_DATA_SIZE  14    sample width per channel (two's complement)
//   FIFO_DEPTH      512   capture FIFO depth in sample pairs; power of 2
//   CAPTURE_LEN     256   sample pairs captured per trigger; 1..65535, may exceed FIFO_DEPTH
// PORTS
//   i_sys_clock      in   1                 single clock; all logic rising-edge
//   i_reset_n        in   1                 asynchronous, active-low reset
//   i_adc_init_done  in   1                 ADC controller ready (active high)
//   i_adc_valid      in   1                 i_adc_data_ch* hold a new sample pair this cycle
//   i_adc_data_ch1   in   ZMOD_DATA_SIZE    channel 1 sample
//   i_adc_data_ch2   in   ZMOD_DATA_SIZE    channel 2 sample
//   i_arm            in   1                 1-cycle pulse: start a capture
//   i_trig_mode      in   2                 00 immediate, 01 rising, 10 falling, 11 = immediate
//   i_trig_ch_sel    in   1                 0 = ch1, 1 = ch2 drives trigger
//   i_trig_level     in   ZMOD_DATA_SIZE    signed trigger threshold
//   o_data           out  32                {sext16(ch2), sext16(ch1)}
//   o_valid          out  1                 o_data valid
//   i_ready          in   1                 consumer accepts o_data when o_valid & i_ready
//   o_busy           out  1                 high in ARMED, CAPTURE, DRAIN
//   o_done           out  1                 sticky: last captured pair consumed; cleared by accepted arm
//   o_overflow       out  1                 sticky: >=1 pair dropped (FIFO full); cleared by accepted arm
// BEHAVIOUR
//   Reset: all outputs 0, FSM IDLE, FIFO empty, counters 0, history-valid flag 0.
//   FSM: IDLE -> ARMED on i_arm & i_adc_init_done (arm otherwise ignored; arm ignored outside IDLE).
//     ARMED -> CAPTURE on trigger sample; CAPTURE -> DRAIN when CAPTURE_LEN pairs handled (written or
//     dropped); DRAIN -> IDLE when FIFO empty, same cycle o_done <= 1.
//   Trigger (evaluated only on i_adc_valid in ARMED; signed compares): prev = last valid sample of selected
//     channel since arm. rising: prev < level && cur >= level; falling: prev >= level && cur < level.
//     First valid sample after arm only loads prev (history-valid=0), cannot trigger in modes 01/10.
//     Immediate: first valid sample after arm triggers.
//   Trigger sample is captured pair #1; CAPTURE accepts each subsequent i_adc_valid pair.
//   FIFO write: on captured pair if not full, or if full and a read occurs same cycle (count unchanged).
//     Else pair dropped, o_overflow <= 1, still counted toward CAPTURE_LEN.
//   Output: first-word-fall-through; pair written at cycle n visible on o_data/o_valid at n+1.
//     o_data/o_valid held stable while o_valid & ~i_ready. o_data = 0 when FIFO empty.
//   Sign-extension: bits [15:14] = bit 13 of ch1, [31:30] = bit 13 of ch2.
//   i_adc_init_done falling while busy: abort to IDLE, flush FIFO, o_done stays 0.
//   Async reset mid-capture: immediate return to reset state, FIFO contents discarded.
// TESTING
//   1 Reset: assert i_reset_n=0 mid-stream -> all outputs 0 next edge, FSM IDLE, o_valid 0.
//   2 Immediate, CAPTURE_LEN=4, ramp ch1=0,1,2.. ch2=-1,-2..: arm -> o_data 0xFFFF_0000, 0xFFFE_0001,
//     0xFFFD_0002, 0xFFFC_0003 in order, then o_done=1, o_busy=0, o_overflow=0.
//   3 Rising, level=100, ch1 = 90,95,99,100,101: first pair captured has ch1=100; 90/95/99 not captured.
//   4 Falling on ch2, level=-8192 boundary: ch2 -8191 -> -8192 triggers only if prev>=level&&cur<level;
//     check no trigger at -8192 (not < -8192), check trigger on 0 -> -1 with level 0.
//   5 Overflow: FIFO_DEPTH=4, CAPTURE_LEN=8, i_ready=0 -> 4 pairs stored, o_overflow=1, DRAIN waits;
//     raise i_ready -> 4 pairs out, then o_done=1. Full+read same cycle -> write accepted.
//   6 Arm during CAPTURE ignored; arm with i_adc_init_done=0 ignored; init_done drop in CAPTURE -> IDLE,
//     o_valid 0, o_done 0.

Source files
------------

// File: rtl/adc1410_capture_if.sv
// Output sample stream from the capture block to the PS/DMA side.
//   data  : {sext16(ch2), sext16(ch1)} sample pair
//   valid : data holds a pair
//   ready : consumer takes data when valid & ready
interface adc1410_capture_if;
  logic [31:0] data;
  logic        valid;
  logic        ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/adc1410_capture.sv
// Zmod ADC1410 capture engine: waits for an armed trigger (immediate / rising /
// falling level crossing on ch1 or ch2), captures CAPTURE_LEN sample pairs into
// a first-word-fall-through FIFO and streams them out over valid/ready.
// Ports:
//   i_sys_clock, i_reset_n           clock, async active-low reset
//   i_adc_init_done                  ADC controller ready; falling while busy aborts
//   i_adc_valid, i_adc_data_ch1/ch2  incoming sample pair
//   i_arm, i_trig_mode, i_trig_ch_sel, i_trig_level   trigger setup
//   m_axis                           output stream (data/valid/ready)
//   o_busy, o_done, o_overflow       status (done/overflow sticky until next arm)
module adc1410_capture #(
  parameter int unsigned ZMOD_DATA_SIZE = 14,
  parameter int unsigned FIFO_DEPTH     = 512,
  parameter int unsigned CAPTURE_LEN    = 256
) (
  input  logic                      i_sys_clock,
  input  logic                      i_reset_n,
  input  logic                      i_adc_init_done,
  input  logic                      i_adc_valid,
  input  logic [ZMOD_DATA_SIZE-1:0] i_adc_data_ch1,
  input  logic [ZMOD_DATA_SIZE-1:0] i_adc_data_ch2,
  input  logic                      i_arm,
  input  logic [1:0]                i_trig_mode,
  input  logic                      i_trig_ch_sel,
  input  logic [ZMOD_DATA_SIZE-1:0] i_trig_level,
  adc1410_capture_if.master         m_axis,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_overflow
);

  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned LW  = 16;
  localparam int unsigned EXT = 16 - ZMOD_DATA_SIZE;
  localparam int unsigned MSB = ZMOD_DATA_SIZE - 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_DRAIN
  } state_t;

  state_t state, state_next;

  // FSM strobes
  logic arm_ok, capture, abort, finish, last_pair;

  // trigger
  logic signed [ZMOD_DATA_SIZE-1:0] cur_smp, prev_smp, level;
  logic hist_valid, trig_hit;

  // capture counter
  logic [LW-1:0] cap_cnt;

  // FIFO
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_next;
  logic [CW-1:0] count, count_next;
  logic          full, rd_en, wr_en, drop;
  logic [31:0]   wr_word, head_next;

  // Trigger evaluation on the selected channel (signed compares)
  always_comb begin
    cur_smp  = i_trig_ch_sel ? $signed(i_adc_data_ch2) : $signed(i_adc_data_ch1);
    level    = $signed(i_trig_level);
    trig_hit = 1'b1;
    case (i_trig_mode)
      2'b01:   trig_hit = hist_valid && (prev_smp < level) && (cur_smp >= level);
      2'b10:   trig_hit = hist_valid && (prev_smp >= level) && (cur_smp < level);
      default: trig_hit = 1'b1;
    endcase
  end

  assign last_pair = (cap_cnt == LW'(CAPTURE_LEN - 1));

  // State register
  always_ff @(posedge i_sys_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and control strobes; losing init_done while busy wins over everything
  always_comb begin
    state_next = state;
    arm_ok     = 1'b0;
    capture    = 1'b0;
    abort      = 1'b0;
    finish     = 1'b0;
    if ((state != S_IDLE) && !i_adc_init_done) begin
      abort      = 1'b1;
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_arm && i_adc_init_done) begin
            arm_ok     = 1'b1;
            state_next = S_ARMED;
          end
        end
        S_ARMED: begin
          // cap_cnt is 0 here, so last_pair only fires for CAPTURE_LEN == 1
          if (i_adc_valid && trig_hit) begin
            capture    = 1'b1;
            state_next = last_pair ? S_DRAIN : S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (i_adc_valid) begin
            capture = 1'b1;
            if (last_pair) begin
              state_next = S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (count == '0) begin
            finish     = 1'b1;
            state_next = S_IDLE;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Status flags
  always_ff @(posedge i_sys_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      o_busy <= (state_next != S_IDLE);
      if (arm_ok) begin
        o_done     <= 1'b0;
        o_overflow <= 1'b0;
      end else begin
        if (finish) o_done <= 1'b1;
        if (drop)   o_overflow <= 1'b1;
      end
    end
  end

  // Trigger history: previous valid sample of the selected channel since arm
  always_ff @(posedge i_sys_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      hist_valid <= 1'b0;
      prev_smp   <= '0;
    end else if (arm_ok) begin
      hist_valid <= 1'b0;
      prev_smp   <= '0;
    end else if ((state == S_ARMED) && i_adc_valid) begin
      hist_valid <= 1'b1;
      prev_smp   <= cur_smp;
    end
  end

  // Pairs handled (written or dropped) in the current capture
  always_ff @(posedge i_sys_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cap_cnt <= '0;
    end else if (arm_ok) begin
      cap_cnt <= '0;
    end else if (capture) begin
      cap_cnt <= cap_cnt + LW'(1);
    end
  end

  // FIFO control; a full FIFO still accepts a write when a read frees a slot the same cycle
  always_comb begin
    wr_word     = {{EXT{i_adc_data_ch2[MSB]}}, i_adc_data_ch2,
                   {EXT{i_adc_data_ch1[MSB]}}, i_adc_data_ch1};
    full        = (count == CW'(FIFO_DEPTH));
    rd_en       = m_axis.valid && m_axis.ready;
    wr_en       = capture && (!full || rd_en);
    drop        = capture && !wr_en;
    rd_ptr_next = rd_ptr + AW'(rd_en);
    count_next  = count + CW'(wr_en) - CW'(rd_en);
    // Bypass when the word being written becomes the new head
    head_next   = (wr_en && (wr_ptr == rd_ptr_next)) ? wr_word : mem[rd_ptr_next];
  end

  always_ff @(posedge i_sys_clock) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_word;
    end
  end

  // Pointers plus registered head word (first-word-fall-through)
  always_ff @(posedge i_sys_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      m_axis.valid <= 1'b0;
      m_axis.data  <= '0;
    end else if (abort) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      m_axis.valid <= 1'b0;
      m_axis.data  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr       <= rd_ptr_next;
      count        <= count_next;
      m_axis.valid <= (count_next != '0);
      m_axis.data  <= (count_next != '0) ? head_next : '0;
    end
  end

endmodule

// File: tb/tb_adc1410_capture.sv
// Directed bench for adc1410_capture with a scoreboard of expected stream words.
module tb_adc1410_capture;

  localparam int unsigned DW    = 14;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LEN   = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          init_done = 1'b0;
  logic          adc_valid = 1'b0;
  logic [DW-1:0] ch1 = '0;
  logic [DW-1:0] ch2 = '0;
  logic          arm = 1'b0;
  logic [1:0]    trig_mode = 2'b00;
  logic          trig_sel = 1'b0;
  logic [DW-1:0] trig_level = '0;
  logic          busy, done, overflow;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb [$];
  logic [31:0] mon_exp;
  logic [31:0] held;

  adc1410_capture_if stream ();

  adc1410_capture #(
    .ZMOD_DATA_SIZE (DW),
    .FIFO_DEPTH     (DEPTH),
    .CAPTURE_LEN    (LEN)
  ) dut (
    .i_sys_clock     (clk),
    .i_reset_n       (rst_n),
    .i_adc_init_done (init_done),
    .i_adc_valid     (adc_valid),
    .i_adc_data_ch1  (ch1),
    .i_adc_data_ch2  (ch2),
    .i_arm           (arm),
    .i_trig_mode     (trig_mode),
    .i_trig_ch_sel   (trig_sel),
    .i_trig_level    (trig_level),
    .m_axis          (stream),
    .o_busy          (busy),
    .o_done          (done),
    .o_overflow      (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Expected stream word: both channels sign-extended to 16 bits
  function automatic logic [31:0] pack(input int c1, input int c2);
    logic [15:0] lo, hi;
    lo = 16'(c1);
    hi = 16'(c2);
    return {hi, lo};
  endfunction

  // Consumer side: every accepted word must match the scoreboard head
  always @(negedge clk) begin
    if (rst_n && stream.valid && stream.ready) begin
      if (sb.size() != 0) mon_exp = sb.pop_front();
      else                mon_exp = 32'bx;
      chk_word("stream_word", stream.data, mon_exp);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic [1:0] mode, input logic sel, input int lvl);
    trig_mode  = mode;
    trig_sel   = sel;
    trig_level = DW'(lvl);
    arm        = 1'b1;
    tick();
    arm        = 1'b0;
  endtask

  task automatic sample(input int c1, input int c2, input bit cap);
    adc_valid = 1'b1;
    ch1       = DW'(c1);
    ch2       = DW'(c2);
    if (cap) sb.push_back(pack(c1, c2));
    tick();
    adc_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    chk_bit(tag, done, 1'b1);
  endtask

  initial begin
    stream.ready = 1'b1;
    repeat (3) tick();
    rst_n     = 1'b1;
    init_done = 1'b1;
    tick();

    // Reset state
    chk_word("rst_data", stream.data, 32'h0);
    chk_bit("rst_valid", stream.valid, 1'b0);
    chk_bit("rst_busy", busy, 1'b0);
    chk_bit("rst_done", done, 1'b0);
    chk_bit("rst_ovf", overflow, 1'b0);

    // Immediate trigger, ramp
    do_arm(2'b00, 1'b0, 0);
    chk_bit("imm_busy", busy, 1'b1);
    for (int i = 0; i < 8; i++) sample(i, -(i + 1), 1'b1);
    sample(50, 50, 1'b0);
    wait_done("imm_done");
    chk_bit("imm_busy_end", busy, 1'b0);
    chk_bit("imm_ovf", overflow, 1'b0);
    chk_word("imm_sb_left", 32'(sb.size()), 32'd0);

    // Rising on ch1, level 100; first sample only loads history
    do_arm(2'b01, 1'b0, 100);
    chk_bit("rise_done_clr", done, 1'b0);
    sample(150, -1, 1'b0);
    sample(90, -2, 1'b0);
    sample(95, -3, 1'b0);
    sample(99, -4, 1'b0);
    chk_bit("rise_not_trig", stream.valid, 1'b0);
    for (int i = 0; i < 8; i++) sample(100 + i, -10 - i, 1'b1);
    wait_done("rise_done");
    chk_word("rise_sb_left", 32'(sb.size()), 32'd0);

    // Falling on ch2 at the most negative level can never trigger
    do_arm(2'b10, 1'b1, -8192);
    sample(0, -8191, 1'b0);
    sample(0, -8192, 1'b0);
    sample(0, -8191, 1'b0);
    sample(0, -8192, 1'b0);
    chk_bit("fall_min_busy", busy, 1'b1);
    chk_bit("fall_min_valid", stream.valid, 1'b0);
    init_done = 1'b0;
    tick();
    chk_bit("abort_armed_busy", busy, 1'b0);
    chk_bit("abort_armed_done", done, 1'b0);
    init_done = 1'b1;
    tick();

    // Falling on ch2, level 0: 5 -> 0 no, 0 -> -1 triggers
    do_arm(2'b10, 1'b1, 0);
    sample(1, 5, 1'b0);
    sample(2, 0, 1'b0);
    sample(-8192, -1, 1'b1);
    for (int i = 0; i < 7; i++) sample(8191 - i, -2 - i, 1'b1);
    wait_done("fall_done");
    chk_word("fall_sb_left", 32'(sb.size()), 32'd0);

    // Overflow: consumer stalled, mode 11 acts as immediate
    stream.ready = 1'b0;
    do_arm(2'b11, 1'b0, 0);
    for (int i = 0; i < 8; i++) sample(1000 + i, -1000 - i, (i < 4));
    tick();
    chk_bit("ovf_flag", overflow, 1'b1);
    chk_bit("ovf_busy", busy, 1'b1);
    chk_bit("ovf_valid", stream.valid, 1'b1);
    chk_word("ovf_head", stream.data, pack(1000, -1000));
    held = stream.data;
    repeat (3) tick();
    chk_word("ovf_hold", stream.data, held);
    chk_bit("ovf_not_done", done, 1'b0);
    stream.ready = 1'b1;
    wait_done("ovf_done");
    chk_bit("ovf_sticky", overflow, 1'b1);
    chk_word("ovf_sb_left", 32'(sb.size()), 32'd0);

    // Full FIFO with a read in the same cycle still accepts the write
    stream.ready = 1'b0;
    do_arm(2'b00, 1'b0, 0);
    chk_bit("fr_ovf_clr", overflow, 1'b0);
    for (int i = 0; i < 4; i++) sample(2000 + i, 2000 + i, 1'b1);
    stream.ready = 1'b1;
    for (int i = 4; i < 8; i++) sample(2000 + i, 2000 + i, 1'b1);
    wait_done("fr_done");
    chk_bit("fr_ovf", overflow, 1'b0);
    chk_word("fr_sb_left", 32'(sb.size()), 32'd0);

    // Arm during CAPTURE is ignored
    do_arm(2'b00, 1'b0, 0);
    for (int i = 0; i < 3; i++) sample(3000 + i, -3000 - i, 1'b1);
    do_arm(2'b00, 1'b0, 0);
    chk_bit("rearm_busy", busy, 1'b1);
    for (int i = 3; i < 8; i++) sample(3000 + i, -3000 - i, 1'b1);
    wait_done("rearm_done");
    chk_word("rearm_sb_left", 32'(sb.size()), 32'd0);

    // Arm with init_done low is ignored
    init_done = 1'b0;
    do_arm(2'b00, 1'b0, 0);
    chk_bit("noinit_busy", busy, 1'b0);
    init_done = 1'b1;
    sample(1, 1, 1'b0);
    sample(2, 2, 1'b0);
    chk_bit("noinit_valid", stream.valid, 1'b0);
    chk_bit("noinit_done", done, 1'b1);

    // init_done drop during CAPTURE aborts and flushes
    stream.ready = 1'b0;
    do_arm(2'b00, 1'b0, 0);
    for (int i = 0; i < 3; i++) sample(4000 + i, 4000 + i, 1'b0);
    chk_bit("abort_pre_valid", stream.valid, 1'b1);
    init_done = 1'b0;
    tick();
    chk_bit("abort_valid", stream.valid, 1'b0);
    chk_bit("abort_busy", busy, 1'b0);
    chk_bit("abort_done", done, 1'b0);
    chk_word("abort_data", stream.data, 32'h0);
    init_done = 1'b1;
    stream.ready = 1'b1;
    repeat (3) tick();
    chk_bit("abort_flushed", stream.valid, 1'b0);

    // Async reset mid-capture with a full FIFO and overflow set
    stream.ready = 1'b0;
    do_arm(2'b00, 1'b0, 0);
    for (int i = 0; i < 6; i++) sample(5000 + i, 5000 + i, 1'b0);
    chk_bit("mid_ovf", overflow, 1'b1);
    rst_n = 1'b0;
    tick();
    chk_word("mid_rst_data", stream.data, 32'h0);
    chk_bit("mid_rst_valid", stream.valid, 1'b0);
    chk_bit("mid_rst_busy", busy, 1'b0);
    chk_bit("mid_rst_ovf", overflow, 1'b0);
    chk_bit("mid_rst_done", done, 1'b0);
    rst_n = 1'b1;
    stream.ready = 1'b1;
    tick();

    // Normal capture after reset; discarded contents must not reappear
    do_arm(2'b00, 1'b0, 0);
    for (int i = 0; i < 8; i++) sample(-i, 8191 - i, 1'b1);
    wait_done("post_rst_done");
    chk_word("post_rst_sb_left", 32'(sb.size()), 32'd0);

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
